// File: rtl/pnode_pkt_rx_if.sv
// pnode_pkt_rx_if: tap-side read port and Avalon-ST packet output of one node's receive stage.
interface pnode_pkt_rx_if;
    logic        in_ready;
    logic        in_valid;
    logic [73:0] in_data;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_valid;
    logic        out_ready;

    modport master (
        input  in_ready,
        output in_valid, in_data,
        input  out_data, out_sop, out_eop, out_valid,
        output out_ready
    );

    modport slave (
        output in_ready,
        input  in_valid, in_data,
        output out_data, out_sop, out_eop, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/pnode_pkt_rx.sv
// pnode_pkt_rx: filters one channel from a tap, reassembles packets in a circular buffer, replays committed packets.
// Define PNODE_RX_STATS_EN to build the saturating pkt_count/drop_count counters; otherwise they read 0.
module pnode_pkt_rx #(
    parameter int NODE_ID       = 0,
    parameter int DEPTH         = 64,
    parameter int MAX_PKT_WORDS = DEPTH - 2
) (
    input  logic          clock,
    input  logic          reset_n,
    pnode_pkt_rx_if.slave bus,
    output logic [15:0]   pkt_count,
    output logic [15:0]   drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP  = (AW+1)'(DEPTH);
    localparam logic [AW:0] MAXL = (AW+1)'(MAX_PKT_WORDS);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

    state_t      state, state_n;
    logic [AW:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, start_ptr, start_ptr_n;
    logic [AW:0] len, len_n, rd_ptr, waddr, free;
    logic        m, sop, eop, we, w_sop, w_eop, pkt_inc, drop_inc, rst_done;
    logic        re, load, q_valid, out_valid_q, out_sop_q, out_eop_q;
    logic [63:0] out_data_q;
    logic [65:0] mem [DEPTH];
    logic [65:0] q;

    assign m    = bus.in_valid && bus.in_data[73:66] == 8'(NODE_ID);
    assign sop  = bus.in_data[65];
    assign eop  = bus.in_data[64];
    // wr_ptr includes the uncommitted packet, so space is reserved while capturing
    assign free = CAP - (wr_ptr - rd_ptr);
    assign bus.in_ready = rst_done && free >= (AW+1)'(2);

    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        commit_ptr_n = commit_ptr;
        start_ptr_n  = start_ptr;
        len_n        = len;
        waddr        = wr_ptr;
        we           = 1'b0;
        w_sop        = 1'b0;
        w_eop        = 1'b0;
        pkt_inc      = 1'b0;
        drop_inc     = 1'b0;
        if (m) begin
            if (sop) begin
                // a sop mid-capture abandons the partial packet and reuses its space
                waddr        = (state == CAPTURE) ? start_ptr : wr_ptr;
                drop_inc     = state == CAPTURE;
                we           = 1'b1;
                w_sop        = 1'b1;
                w_eop        = eop;
                start_ptr_n  = waddr;
                len_n        = ONE;
                wr_ptr_n     = waddr + ONE;
                commit_ptr_n = eop ? waddr + ONE : commit_ptr;
                pkt_inc      = eop;
                state_n      = eop ? IDLE : CAPTURE;
            end else if (state == IDLE) begin
                drop_inc = 1'b1;
            end else if (state == DROP) begin
                state_n = eop ? IDLE : DROP;
            end else if (eop) begin
                we           = 1'b1;
                w_eop        = 1'b1;
                wr_ptr_n     = wr_ptr + ONE;
                commit_ptr_n = wr_ptr + ONE;
                pkt_inc      = 1'b1;
                state_n      = IDLE;
            end else if (len == MAXL) begin
                wr_ptr_n = start_ptr;
                drop_inc = 1'b1;
                state_n  = DROP;
            end else begin
                we       = 1'b1;
                wr_ptr_n = wr_ptr + ONE;
                len_n    = len + ONE;
            end
        end
    end

    // the RAM output register only advances when the output register can take its word
    assign load = q_valid && (!out_valid_q || bus.out_ready);
    assign re   = commit_ptr != rd_ptr && (!q_valid || load);

    always_ff @(posedge clock) begin
        if (we) mem[waddr[AW-1:0]] <= {w_sop, w_eop, bus.in_data[63:0]};
        if (re) q <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            start_ptr  <= '0;
            len        <= '0;
            rst_done   <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            commit_ptr <= commit_ptr_n;
            start_ptr  <= start_ptr_n;
            len        <= len_n;
            rst_done   <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            q_valid     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_ptr      <= rd_ptr + {{AW{1'b0}}, re};
            q_valid     <= re || (q_valid && !load);
            out_valid_q <= load || (out_valid_q && !bus.out_ready);
            if (load) {out_sop_q, out_eop_q, out_data_q} <= q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_data  = out_data_q;

`ifdef PNODE_RX_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (pkt_inc && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = pkt_inc | drop_inc;
    assign pkt_count    = '0;
    assign drop_count   = '0;
`endif
endmodule
